// File: rtl/lc3_pkg.sv
// LC-3 fetch shared definitions.
// PC source selects and fetch FSM state encoding.
package lc3_pkg;

    localparam logic [1:0] PC_MUX_INC = 2'b00;
    localparam logic [1:0] PC_MUX_BUS = 2'b01;
    localparam logic [1:0] PC_MUX_JMP = 2'b10;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_WAIT = 2'b10,
        FS_HOLD = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_timer.sv
// LC-3 fetch memory-timeout counter.
// Counts ticks since the last clear; flags the LIMIT-th tick.
module lc3_fetch_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = tick && !clear && (cnt_q == LAST);

    // next count: clear wins, expiry restarts, tick advances
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch unit.
// Drives PC load/select, memory read and the IR handshake.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] pc_in,
    output logic        pc_ld,
    output logic [1:0]  pc_mux,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic         mem_en_q, mem_en_d;
    logic [15:0]  mem_addr_q, mem_addr_d;
    logic [15:0]  ir_out_q, ir_out_d;
    logic         ir_valid_q, ir_valid_d;
    logic         fetch_err_q, fetch_err_d;
    logic         squash_q, squash_d;

    logic tmr_tick;
    logic tmr_clear;
    logic tmr_expired;

    assign tmr_tick  = (state_q == FS_WAIT) && !mem_r;
    assign tmr_clear = (state_q == FS_REQ) || mem_r;

    lc3_fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    // PC strobe: redirect beats the REQ increment; bad selects fold to jump
    always_comb begin
        pc_ld  = 1'b0;
        pc_mux = PC_MUX_INC;
        if (!rst) begin
            if (redirect_valid) begin
                pc_ld  = 1'b1;
                pc_mux = (redirect_sel == PC_MUX_BUS) ? PC_MUX_BUS : PC_MUX_JMP;
            end else if (state_q == FS_REQ) begin
                pc_ld  = 1'b1;
            end
        end
    end

    // fetch FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        ir_out_d    = ir_out_q;
        ir_valid_d  = ir_valid_q;
        squash_d    = squash_q;
        fetch_err_d = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (run) state_d = FS_REQ;
            end
            FS_REQ: begin
                mem_addr_d = pc_in;
                state_d    = FS_WAIT;
                if (redirect_valid) squash_d = 1'b1;
            end
            FS_WAIT: begin
                if (mem_r) begin
                    squash_d = 1'b0;
                    if (squash_q || redirect_valid) begin
                        state_d = run ? FS_REQ : FS_IDLE;
                    end else begin
                        ir_out_d   = mem_rdata;
                        ir_valid_d = 1'b1;
                        state_d    = FS_HOLD;
                    end
                end else if (tmr_expired) begin
                    fetch_err_d = 1'b1;
                    squash_d    = 1'b0;
                    state_d     = FS_IDLE;
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (ir_ready || redirect_valid) begin
                    ir_valid_d = 1'b0;
                    state_d    = run ? FS_REQ : FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        mem_en_d = (state_d == FS_REQ) || (state_d == FS_WAIT);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            ir_out_q    <= 16'h0000;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            ir_out_q    <= ir_out_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            squash_q    <= squash_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign ir_out    = ir_out_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;

endmodule
